// File: rtl/data_mem_pkg.sv
// rtl/data_mem_pkg.sv - size encodings, controller states and byte-lane helpers for data_mem_ctrl
package data_mem_pkg;

  // Access size encodings; 2'b11 is handled exactly like a word access
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Controller states
  typedef enum logic [1:0] {
    UPLOAD = 2'd0,
    IDLE   = 2'd1,
    RMW_WR = 2'd2
  } state_t;

  // Byte and half accesses need a read-modify-write on stores
  function automatic logic is_subword(input logic [1:0] size);
    return (size == SIZE_BYTE) || (size == SIZE_HALF);
  endfunction

  // Half on an odd byte, or word not on a 4-byte boundary
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic mis;
    case (size)
      SIZE_BYTE: mis = 1'b0;
      SIZE_HALF: mis = off[0];
      default:   mis = (off != 2'b00);
    endcase
    return mis;
  endfunction

  // Select the addressed lane of a memory word and sign/zero extend it
  function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                               input logic [1:0]  off,
                                               input logic [1:0]  size,
                                               input logic        uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      SIZE_BYTE: r = {{24{b[7] & ~uns}}, b};
      SIZE_HALF: r = {{16{h[15] & ~uns}}, h};
      default:   r = word;
    endcase
    return r;
  endfunction

  // Overlay low-aligned store data onto the addressed lane of the old word
  function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                             input logic [31:0] wdata,
                                             input logic [1:0]  off,
                                             input logic [1:0]  size);
    logic [31:0] r;
    r = old_word;
    case (size)
      SIZE_BYTE: begin
        case (off)
          2'd0:    r[7:0]   = wdata[7:0];
          2'd1:    r[15:8]  = wdata[7:0];
          2'd2:    r[23:16] = wdata[7:0];
          default: r[31:24] = wdata[7:0];
        endcase
      end
      SIZE_HALF: begin
        if (off[1]) r[31:16] = wdata[15:0];
        else        r[15:0]  = wdata[15:0];
      end
      default: r = wdata;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_lane_unit.sv
// rtl/mem_lane_unit.sv - combinational store merge and load lane extract/extension
module mem_lane_unit (
  input  logic [31:0] ld_word,
  input  logic [1:0]  ld_off,
  input  logic [1:0]  ld_size,
  input  logic        ld_unsigned,
  output logic [31:0] ld_data,
  input  logic [31:0] st_old,
  input  logic [31:0] st_data,
  input  logic [1:0]  st_off,
  input  logic [1:0]  st_size,
  output logic [31:0] st_merged
);
  import data_mem_pkg::*;

  // Load formatting and store merging are independent pure lane operations
  always_comb begin
    ld_data   = lane_extract(ld_word, ld_off, ld_size, ld_unsigned);
    st_merged = lane_merge(st_old, st_data, st_off, st_size);
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - data memory controller with sub-word RMW and upload port; optional MEM_MISALIGN_CHK_EN
module data_mem_ctrl #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       wdata_i,
  output logic              ready_o,
  output logic              rvalid_o,
  output logic [31:0]       rdata_o,
  output logic              misalign_o,
  input  logic              upg_rst_i,
  input  logic              upg_done_i,
  input  logic              upg_wen_i,
  input  logic [ADDR_W:0]   upg_adr_i,
  input  logic [31:0]       upg_dat_i
);
  import data_mem_pkg::*;

  localparam int DEPTH = 2 ** ADDR_W;

  logic [31:0]       mem [DEPTH];

  state_t            state;
  logic              ready_q;
  logic              rvalid_q;
  logic              mis_q;
  logic [1:0]        off_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [31:0]       wdata_q;
  logic [ADDR_W-1:0] idx_q;
  logic [31:0]       rd_q;

  logic              run;
  logic              accept;
  logic              mis_now;
  logic              wr_word;
  logic              go_rmw;
  logic              wr_rmw;
  logic              wr_upg;
  logic [ADDR_W-1:0] idx;
  logic [31:0]       ld_data;
  logic [31:0]       merged;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;
  logic              unused_addr_hi;

  // Upload mode is entered while neither the upgrade reset nor the done flag is high
  assign run    = upg_rst_i | upg_done_i;
  // Address bits above the array wrap around
  assign idx    = addr_i[ADDR_W+1:2];
  assign unused_addr_hi = ^addr_i[31:ADDR_W+2];

  // ready_q is cleared by reset so no request is taken until the first clean edge
  assign ready_o = ready_q & run;
  assign accept  = req_i & ready_o;

`ifdef MEM_MISALIGN_CHK_EN
  assign mis_now    = is_misaligned(size_i, addr_i[1:0]);
  assign misalign_o = mis_q;
`else
  assign mis_now    = 1'b0;
  assign misalign_o = 1'b0;
`endif

  assign wr_word = accept & we_i & ~mis_now & ~is_subword(size_i);
  assign go_rmw  = accept & we_i & ~mis_now &  is_subword(size_i);
  // Async reset forces IDLE, so a reset during RMW_WR drops the pending write
  assign wr_rmw  = (state == RMW_WR);
  assign wr_upg  = (state == UPLOAD) & upg_wen_i & upg_adr_i[ADDR_W];

  mem_lane_unit u_lane (
    .ld_word     (rd_q),
    .ld_off      (off_q),
    .ld_size     (size_q),
    .ld_unsigned (uns_q),
    .ld_data     (ld_data),
    .st_old      (rd_q),
    .st_data     (wdata_q),
    .st_off      (off_q),
    .st_size     (size_q),
    .st_merged   (merged)
  );

  // Single write port: CPU word store, RMW merge, or upload write (mutually exclusive by state)
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = idx;
    mem_wdata = wdata_i;
    if (wr_word) begin
      mem_we = 1'b1;
    end else if (wr_rmw) begin
      mem_we    = 1'b1;
      mem_waddr = idx_q;
      mem_wdata = merged;
    end else if (wr_upg) begin
      mem_we    = 1'b1;
      mem_waddr = upg_adr_i[ADDR_W-1:0];
      mem_wdata = upg_dat_i;
    end
  end

  // Memory array with synchronous read; contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    if (accept) rd_q <= mem[idx];
  end

  // Controller FSM and registered handshake/response flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ready_q  <= 1'b0;
      rvalid_q <= 1'b0;
      mis_q    <= 1'b0;
      off_q    <= '0;
      size_q   <= '0;
      uns_q    <= 1'b0;
      wdata_q  <= '0;
      idx_q    <= '0;
    end else begin
      rvalid_q <= accept & ~we_i;
      mis_q    <= accept & mis_now;
      if (accept) begin
        off_q   <= addr_i[1:0];
        size_q  <= size_i;
        uns_q   <= unsigned_i;
        wdata_q <= wdata_i;
        idx_q   <= idx;
      end
      case (state)
        IDLE: begin
          if (!run) begin
            state   <= UPLOAD;
            ready_q <= 1'b0;
          end else if (go_rmw) begin
            state   <= RMW_WR;
            ready_q <= 1'b0;
          end else begin
            ready_q <= 1'b1;
          end
        end
        RMW_WR: begin
          state   <= run ? IDLE : UPLOAD;
          ready_q <= run;
        end
        UPLOAD: begin
          if (run) state <= IDLE;
          ready_q <= run;
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = (rvalid_q & ~mis_q) ? ld_data : 32'h0;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - scoreboard bench for data_mem_ctrl
module tb_data_mem_ctrl;

  localparam int ADDR_W = 14;
`ifdef MEM_MISALIGN_CHK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              req_i;
  logic              we_i;
  logic [1:0]        size_i;
  logic              unsigned_i;
  logic [31:0]       addr_i;
  logic [31:0]       wdata_i;
  logic              ready_o;
  logic              rvalid_o;
  logic [31:0]       rdata_o;
  logic              misalign_o;
  logic              upg_rst_i;
  logic              upg_done_i;
  logic              upg_wen_i;
  logic [ADDR_W:0]   upg_adr_i;
  logic [31:0]       upg_dat_i;

  typedef struct {
    logic [31:0] data;
    logic        mis;
    int          due;
    int          id;
  } exp_t;

  exp_t sb_q[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;
  int   ld_id      = 0;

  data_mem_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req_i),
    .we_i       (we_i),
    .size_i     (size_i),
    .unsigned_i (unsigned_i),
    .addr_i     (addr_i),
    .wdata_i    (wdata_i),
    .ready_o    (ready_o),
    .rvalid_o   (rvalid_o),
    .rdata_o    (rdata_o),
    .misalign_o (misalign_o),
    .upg_rst_i  (upg_rst_i),
    .upg_done_i (upg_done_i),
    .upg_wen_i  (upg_wen_i),
    .upg_adr_i  (upg_adr_i),
    .upg_dat_i  (upg_dat_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic neg_chk_ready(input string nm, input logic exp);
    @(negedge clk);
    chk(nm, {31'b0, ready_o}, {31'b0, exp});
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the accepting edge
  task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_d, input logic exp_m);
    int n;
    exp_t e;
    n = 0;
    req_i = 1'b1; we_i = w; size_i = sz; unsigned_i = u; addr_i = a; wdata_i = wd;
    @(negedge clk);
    while (ready_o !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", {31'b0, ready_o}, 32'd1);
    @(posedge clk);
    #1;
    req_i = 1'b0;
    if (!w) begin
      e.data = exp_d; e.mis = exp_m; e.due = cyc; e.id = ld_id;
      sb_q.push_back(e);
      ld_id++;
    end
  endtask

  // Monitor: every load response is matched against the oldest expected entry
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (rvalid_o) begin
        if (sb_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_rvalid: rvalid_o=1 with no load pending, expected 0");
        end else begin
          e = sb_q.pop_front();
          chk($sformatf("load_data[%0d]", e.id), rdata_o, e.data);
          chk($sformatf("load_misalign[%0d]", e.id), {31'b0, misalign_o}, {31'b0, e.mis});
          chk($sformatf("load_latency[%0d]", e.id), cyc, e.due);
        end
      end else begin
        chk("rdata_idle", rdata_o, 32'h0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_i = 1'b0; we_i = 1'b0; size_i = 2'b10; unsigned_i = 1'b0;
    addr_i = '0; wdata_i = '0;
    upg_rst_i = 1'b1; upg_done_i = 1'b0; upg_wen_i = 1'b0; upg_adr_i = '0; upg_dat_i = '0;

    @(negedge clk);
    chk("reset_ready",    {31'b0, ready_o},    32'd0);
    chk("reset_rvalid",   {31'b0, rvalid_o},   32'd0);
    chk("reset_rdata",    rdata_o,             32'd0);
    chk("reset_misalign", {31'b0, misalign_o}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk);
    neg_chk_ready("ready_after_reset", 1'b1);

    // word store then load
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'h8765_4321, 32'h0, 1'b0);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h8765_4321, 1'b0);

    // byte store through RMW, ready drops for one cycle
    issue(1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_00FF, 32'h0, 1'b0);
    neg_chk_ready("rmw_ready_low", 1'b0);
    neg_chk_ready("rmw_ready_back", 1'b1);
    issue(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 32'hFFFF_FFFF, 1'b0);
    issue(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 32'h0000_00FF, 1'b0);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h8765_FF21, 1'b0);
    issue(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'hFFFF_8765, 1'b0);
    issue(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 32'h0000_FF21, 1'b0);
    issue(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h8765_FF21, 1'b0);

    // address wrap-around
    issue(1'b1, 2'b10, 1'b0, 32'h0, 32'hA5A5_0001, 32'h0, 1'b0);
    issue(1'b0, 2'b10, 1'b0, 32'h0001_0000, 32'h0, 32'hA5A5_0001, 1'b0);
    issue(1'b1, 2'b10, 1'b0, 32'h0001_0004, 32'h0BAD_0004, 32'h0, 1'b0);
    issue(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 32'h0BAD_0004, 1'b0);

    // upload mode
    upg_rst_i = 1'b0;
    neg_chk_ready("upload_ready", 1'b0);
    req_i = 1'b1; we_i = 1'b0; size_i = 2'b10; addr_i = 32'h10;
    @(posedge clk); #1;
    @(posedge clk); #1;
    req_i = 1'b0;
    upg_wen_i = 1'b1; upg_adr_i = {1'b1, 14'd5}; upg_dat_i = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    upg_adr_i = {1'b0, 14'd5}; upg_dat_i = 32'h1234_5678;
    @(posedge clk); #1;
    upg_wen_i = 1'b0;
    upg_done_i = 1'b1;
    neg_chk_ready("upload_exit_wait", 1'b0);
    neg_chk_ready("upload_exit_ready", 1'b1);
    issue(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 32'hDEAD_BEEF, 1'b0);

    // run drops during RMW_WR: write completes, then upload
    issue(1'b1, 2'b10, 1'b0, 32'h20, 32'h1122_3344, 32'h0, 1'b0);
    issue(1'b1, 2'b01, 1'b0, 32'h22, 32'h0000_BEEF, 32'h0, 1'b0);
    upg_done_i = 1'b0;
    neg_chk_ready("rmw_run_low_ready", 1'b0);
    upg_wen_i = 1'b1; upg_adr_i = {1'b1, 14'd12}; upg_dat_i = 32'hCAFE_F00D;
    @(posedge clk); #1;
    upg_wen_i = 1'b0;
    upg_done_i = 1'b1;
    neg_chk_ready("rmw_upload_wait", 1'b0);
    neg_chk_ready("rmw_upload_exit", 1'b1);
    issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'hBEEF_3344, 1'b0);
    issue(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 32'hCAFE_F00D, 1'b0);

    // reset during RMW_WR aborts the merge write
    issue(1'b1, 2'b01, 1'b0, 32'h22, 32'h0000_5555, 32'h0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_rmw_ready",  {31'b0, ready_o},  32'd0);
    chk("rst_rmw_rvalid", {31'b0, rvalid_o}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'hBEEF_3344, 1'b0);

    // misaligned accesses
    issue(1'b0, 2'b10, 1'b0, 32'h13, 32'h0, CHK_EN ? 32'h0 : 32'h8765_FF21, CHK_EN);
    issue(1'b1, 2'b10, 1'b0, 32'h12, 32'hFFFF_FFFF, 32'h0, 1'b0);
    @(negedge clk);
    chk("store_misalign", {31'b0, misalign_o}, {31'b0, CHK_EN});
    @(posedge clk); #1;
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, CHK_EN ? 32'h8765_FF21 : 32'hFFFF_FFFF, 1'b0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_empty", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, giving word-address width; depth is 2**ADDR_W 32-bit words.
REQ-002 SHALL have ports: clk in 1, the single clock; rst in 1, asynchronous active-high reset.
REQ-003 SHALL have ports: req_i in 1, access request; we_i in 1, store when 1; size_i in 2, 00 byte / 01 half / 10 word / 11 treated as word; unsigned_i in 1, zero-extend loads.
REQ-004 SHALL have ports: addr_i in 32, byte address; wdata_i in 32, store data, low-aligned.
REQ-005 SHALL have ports: ready_o out 1, request accepted this cycle; rvalid_o out 1, load data valid; rdata_o out 32, extended load data; misalign_o out 1, misaligned-access pulse.
REQ-006 SHALL have ports: upg_rst_i in 1, high = normal mode; upg_done_i in 1, upload finished; upg_wen_i in 1; upg_adr_i in ADDR_W+1, bit ADDR_W selects data memory; upg_dat_i in 32.

Function
REQ-007 SHALL derive run = upg_rst_i | upg_done_i; run=0 is upload mode.
REQ-008 SHALL implement FSM states UPLOAD, IDLE, RMW_WR.
REQ-009 IDLE: ready_o=1 when run=1; request accepted when req_i & ready_o.
REQ-010 Word index SHALL be addr_i[ADDR_W+1:2]; higher address bits ignored (wrap-around).
REQ-011 Load: rdata_o/rvalid_o SHALL be driven exactly one cycle after acceptance; rvalid_o is a one-cycle pulse; back-to-back loads sustain one per cycle.
REQ-012 Load byte lane = addr_i[1:0], half lane = addr_i[1]; sign-extend unless unsigned_i=1.
REQ-013 Word store SHALL write in the acceptance cycle; FSM stays IDLE.
REQ-014 Byte/half store SHALL read the word in the acceptance cycle, go to RMW_WR, write the merged word next cycle, ready_o=0 in RMW_WR, then return to IDLE.
REQ-015 A load accepted after any store to the same word SHALL return the stored value.
REQ-016 rdata_o SHALL hold 0 whenever rvalid_o=0.
REQ-017 run=0 in IDLE SHALL move to UPLOAD next cycle; run=0 in RMW_WR SHALL finish the write, then enter UPLOAD.
REQ-018 UPLOAD: ready_o=0, rvalid_o=0; memory written with upg_dat_i at upg_adr_i[ADDR_W-1:0] when upg_wen_i & upg_adr_i[ADDR_W].
REQ-019 UPLOAD to IDLE SHALL occur the cycle after run returns to 1; CPU requests in UPLOAD are ignored, not queued.

Reset
REQ-020 rst SHALL force state IDLE, ready_o=0 for that cycle, rvalid_o=0, rdata_o=0, misalign_o=0.
REQ-021 Memory contents SHALL NOT be cleared by rst.
REQ-022 rst during RMW_WR SHALL abort the pending write; memory word unchanged.

Configuration
REQ-023 With MEM_MISALIGN_CHK_EN defined: half with addr_i[0]=1 or word with addr_i[1:0]!=0 SHALL be accepted, cause no write, return rdata_o=0 with rvalid_o for loads, and pulse misalign_o one cycle after acceptance.
REQ-024 Without MEM_MISALIGN_CHK_EN: misalign_o tied 0; word accesses align down; half uses addr_i[1] only.

Structure
REQ-025 Package data_mem_pkg SHALL hold size encodings, FSM state enum, and lane extract/merge functions.
REQ-026 Sub-module mem_lane_unit SHALL hold combinational store merge and load extract/extension; memory array inferred in data_mem_ctrl with synchronous read.

Verification
REQ-027 sw 0x8765_4321 to 0x10, lw 0x10 -> rdata_o=0x8765_4321 one cycle later, rvalid_o one pulse.
REQ-028 sb 0xFF to 0x11 over 0x8765_4321 -> ready_o low one cycle; lb 0x11 -> 0xFFFF_FFFF; lbu -> 0x0000_00FF; lw -> 0x8765_FF21.
REQ-029 upg_rst_i=0, upg_done_i=0, upg writes 0xDEAD_BEEF to upg_adr_i={1,index 5} -> ready_o=0; upg_done_i=1 then lw 0x14 -> 0xDEAD_BEEF; write with upg_adr_i[ADDR_W]=0 leaves memory unchanged.
REQ-030 sh to 0x22 then run drops during RMW_WR -> write completes, UPLOAD entered next; rst asserted in RMW_WR on a second sh -> word unchanged.
REQ-031 With MEM_MISALIGN_CHK_EN: lw 0x13 -> rdata_o=0, misalign_o=1 one cycle; sw 0x12 -> memory unchanged; without macro lw 0x13 returns word at 0x10.
REQ-032 lw to 4*2**ADDR_W -> returns word at index 0 (wrap).
